// File: rtl/hqm_rf_pg_access_ctl.sv
// Client access and power-sequencing controller for a power-gated two-port register file.
// Gates client requests on power state and returns fixed-latency read data with same-address write forwarding.
module hqm_rf_pg_access_ctl #(
    parameter int AW      = 5,
    parameter int DW      = 96,
    parameter int RD_LAT  = 1,
    parameter int ISO_DLY = 2,
    parameter int PWR_TO  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwr_req,
    output logic          pwr_on,
    output logic          pwr_err,
    input  logic          wr_v,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_v,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_resp_v,
    output logic [DW-1:0] rd_resp_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          pgcb_isol_en,
    output logic          pwr_enable_b_in,
    input  logic          pwr_enable_b_out
);

    localparam int OW    = $clog2(RD_LAT + 2);
    localparam int DLY_W = (ISO_DLY > 1) ? $clog2(ISO_DLY) : 1;
    localparam int TO_W  = $clog2(PWR_TO + 1);

    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ISO_DLY - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(PWR_TO);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PWR_TO - 1);

    typedef enum logic [2:0] {
        S_OFF, S_UP, S_ISO_REL, S_ON, S_DRAIN, S_ISO_SET, S_DN
    } state_t;

    state_t           state, nxt;
    logic [DLY_W-1:0] dly_cnt;
    logic             dly_done;
    logic [TO_W-1:0]  to_cnt;
    logic             ack_wait_nxt;
    logic [OW-1:0]    out_cnt;
    logic             wr_acc, rd_acc, fwd_hit;

    logic             vld_p  [RD_LAT];
    logic             fwd_p  [RD_LAT];
    logic [DW-1:0]    fdat_p [RD_LAT];

    assign wr_acc    = wr_v & wr_ready;
    assign rd_acc    = rd_v & rd_ready;
    assign fwd_hit   = wr_acc & rd_acc & (wr_addr == rd_addr);
    assign mem_we    = wr_acc;
    assign mem_waddr = wr_acc ? wr_addr : '0;
    assign mem_wdata = wr_acc ? wr_data : '0;
    assign mem_re    = rd_acc;
    assign mem_raddr = rd_acc ? rd_addr : '0;

    assign dly_done     = (dly_cnt == DLY_LAST);
    assign ack_wait_nxt = (nxt == S_UP) || (nxt == S_DN);

    always_comb begin
        nxt             = state;
        pgcb_isol_en    = 1'b1;
        pwr_enable_b_in = 1'b1;
        pwr_on          = 1'b0;
        wr_ready        = 1'b0;
        rd_ready        = 1'b0;
        case (state)
            S_OFF: if (pwr_req) nxt = S_UP;
            S_UP: begin
                pwr_enable_b_in = 1'b0;
                if (!pwr_enable_b_out) nxt = S_ISO_REL;
            end
            S_ISO_REL: begin
                pwr_enable_b_in = 1'b0;
                if (dly_done) nxt = S_ON;
            end
            S_ON: begin
                pwr_enable_b_in = 1'b0;
                pgcb_isol_en    = 1'b0;
                pwr_on          = 1'b1;
                wr_ready        = 1'b1;
                rd_ready        = 1'b1;
                if (!pwr_req) nxt = S_DRAIN;
            end
            // Isolation stays released until every accepted read has responded.
            S_DRAIN: begin
                pwr_enable_b_in = 1'b0;
                pgcb_isol_en    = 1'b0;
                if (out_cnt == '0) nxt = S_ISO_SET;
            end
            S_ISO_SET: begin
                pwr_enable_b_in = 1'b0;
                if (dly_done) nxt = S_DN;
            end
            S_DN: if (pwr_enable_b_out) nxt = S_OFF;
            default: nxt = S_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_OFF;
            dly_cnt <= '0;
            to_cnt  <= '0;
            pwr_err <= 1'b0;
            out_cnt <= '0;
        end else begin
            state <= nxt;
            if (((state == S_ISO_REL) || (state == S_ISO_SET)) && !dly_done)
                dly_cnt <= dly_cnt + DLY_W'(1);
            else
                dly_cnt <= '0;
            // Ack-wait counter saturates; the error is sticky and the FSM keeps waiting.
            if (ack_wait_nxt) begin
                if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TO_LAST) pwr_err <= 1'b1;
            end else begin
                to_cnt <= '0;
            end
            case ({rd_acc, rd_resp_v})
                2'b10:   out_cnt <= out_cnt + OW'(1);
                2'b01:   out_cnt <= out_cnt - OW'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // Read pipeline: stage 0 captures the accept, last stage lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
                fwd_p[i] <= 1'b0;
            end
            rd_resp_v    <= 1'b0;
            rd_resp_data <= '0;
        end else begin
            vld_p[0] <= rd_acc;
            fwd_p[0] <= fwd_hit;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                fwd_p[i] <= fwd_p[i-1];
            end
            rd_resp_v <= vld_p[RD_LAT-1];
            if (vld_p[RD_LAT-1])
                rd_resp_data <= fwd_p[RD_LAT-1] ? fdat_p[RD_LAT-1] : mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        fdat_p[0] <= wr_data;
        for (int i = 1; i < RD_LAT; i++) fdat_p[i] <= fdat_p[i-1];
    end

endmodule

// File: tb/tb_hqm_rf_pg_access_ctl.sv
// Directed bench for hqm_rf_pg_access_ctl with a register-file and power-ack model.
module tb_hqm_rf_pg_access_ctl;

    localparam logic [95:0] DA = 96'hA5A5A5A5A5A5A5A5A5A5A5A5;
    localparam logic [95:0] DB = 96'h1;
    localparam logic [95:0] DC = 96'h0123456789ABCDEF01234567;
    localparam logic [95:0] DD = 96'hDEADBEEFCAFEF00D13572468;
    localparam logic [95:0] DX = 96'h111122223333444455556666;
    localparam logic [95:0] DY = 96'h777788889999AAAABBBBCCCC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwr_req = 1'b0;
    logic        pwr_on, pwr_err;
    logic        wr_v = 1'b0, wr_ready;
    logic [4:0]  wr_addr = '0;
    logic [95:0] wr_data = '0;
    logic        rd_v = 1'b0, rd_ready;
    logic [4:0]  rd_addr = '0;
    logic        rd_resp_v;
    logic [95:0] rd_resp_data;
    logic        mem_we, mem_re;
    logic [4:0]  mem_waddr, mem_raddr;
    logic [95:0] mem_wdata;
    logic [95:0] mem_rdata = '0;
    logic        pgcb_isol_en, pwr_enable_b_in, pwr_enable_b_out;

    logic [95:0] mem [32] = '{default: '0};
    logic [2:0]  ack_sh = 3'b111;
    logic        ack_hold = 1'b0;

    int checks = 0;
    int errors = 0;
    int n;

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [95:0] wd;
        logic        rv;
        logic [4:0]  ra;
        logic        ev;
        logic [95:0] ed;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    hqm_rf_pg_access_ctl #(
        .AW(5), .DW(96), .RD_LAT(1), .ISO_DLY(2), .PWR_TO(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .pwr_on(pwr_on), .pwr_err(pwr_err),
        .wr_v(wr_v), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_v(rd_v), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_v(rd_resp_v), .rd_resp_data(rd_resp_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .pgcb_isol_en(pgcb_isol_en), .pwr_enable_b_in(pwr_enable_b_in),
        .pwr_enable_b_out(pwr_enable_b_out)
    );

    // Wrapper model: one-cycle read latency, read-before-write on the same edge.
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    // Power chain acks three cycles after enable; ack_hold forces it off.
    always @(posedge clk) ack_sh <= {ack_sh[1:0], pwr_enable_b_in};
    assign pwr_enable_b_out = ack_hold ? 1'b1 : ack_sh[2];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] pat(input int i);
        return {32'hC0DE0000 + 32'(i), 32'h5A5A5A5A ^ 32'(i), 32'(i * 3)};
    endfunction

    initial begin
        #100000;
        $display("Watchdog expired: FAIL watchdog");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        tbl[0]  = '{1'b1, 5'd5,  DA,    1'b0, 5'd0,  1'b0, '0};
        tbl[1]  = '{1'b1, 5'd30, DC,    1'b1, 5'd5,  1'b0, '0};
        tbl[2]  = '{1'b1, 5'd31, DB,    1'b1, 5'd31, 1'b0, '0};
        tbl[3]  = '{1'b1, 5'd31, DD,    1'b1, 5'd30, 1'b1, DA};
        tbl[4]  = '{1'b0, 5'd0,  '0,    1'b1, 5'd31, 1'b1, DB};
        tbl[5]  = '{1'b0, 5'd0,  '0,    1'b0, 5'd0,  1'b1, DC};
        tbl[6]  = '{1'b0, 5'd0,  '0,    1'b0, 5'd0,  1'b1, DD};
        tbl[7]  = '{1'b1, 5'd7,  DX,    1'b1, 5'd7,  1'b0, '0};
        tbl[8]  = '{1'b0, 5'd0,  '0,    1'b1, 5'd9,  1'b0, '0};
        tbl[9]  = '{1'b1, 5'd9,  DY,    1'b0, 5'd0,  1'b1, DX};
        tbl[10] = '{1'b0, 5'd0,  '0,    1'b0, 5'd0,  1'b1, '0};
        tbl[11] = '{1'b0, 5'd0,  '0,    1'b0, 5'd0,  1'b0, '0};

        // Reset values
        repeat (2) tick();
        chk("rst_isol", pgcb_isol_en, 1'b1);
        chk("rst_en_b", pwr_enable_b_in, 1'b1);
        chk("rst_pwr_on", pwr_on, 1'b0);
        chk("rst_pwr_err", pwr_err, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b0);
        chk("rst_rd_ready", rd_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        chk("rst_resp_v", rd_resp_v, 1'b0);
        chk("rst_resp_data", rd_resp_data, '0);
        rst_n = 1'b1;
        tick();

        // Power-up with a three-cycle ack: ON after cycle 7
        pwr_req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk($sformatf("pwr_on@%0d", c), pwr_on, (c == 7));
            chk($sformatf("isol@%0d", c), pgcb_isol_en, (c < 7));
        end
        chk("pwr_err_up", pwr_err, 1'b0);

        // Vector table: writes, reads, same-cycle collisions
        for (int i = 0; i < 12; i++) begin
            wr_v = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_v = tbl[i].rv; rd_addr = tbl[i].ra;
            #1;
            chk($sformatf("mem_we[%0d]", i), mem_we, tbl[i].wv);
            chk($sformatf("mem_re[%0d]", i), mem_re, tbl[i].rv);
            if (tbl[i].wv) chk($sformatf("mem_waddr[%0d]", i), mem_waddr, tbl[i].wa);
            chk($sformatf("resp_v[%0d]", i), rd_resp_v, tbl[i].ev);
            if (tbl[i].ev) chk($sformatf("resp_data[%0d]", i), rd_resp_data, tbl[i].ed);
            tick();
        end
        wr_v = 1'b0; rd_v = 1'b0;

        // Fill the array, then stream reads 0..31 and drop pwr_req on the last accept
        for (int i = 0; i < 32; i++) begin
            wr_v = 1'b1; wr_addr = 5'(i); wr_data = pat(i);
            tick();
        end
        wr_v = 1'b0;
        for (int i = 0; i < 34; i++) begin
            rd_v = (i < 32);
            rd_addr = 5'(i % 32);
            if (i == 31) pwr_req = 1'b0;
            #1;
            if (i >= 2) begin
                chk($sformatf("b2b_v[%0d]", i - 2), rd_resp_v, 1'b1);
                chk($sformatf("b2b_d[%0d]", i - 2), rd_resp_data, pat(i - 2));
            end
            if (i == 32) begin
                chk("drain_wr_ready", wr_ready, 1'b0);
                chk("drain_rd_ready", rd_ready, 1'b0);
            end
            if (i == 33) chk("isol_after_last_resp", pgcb_isol_en, 1'b0);
            tick();
        end
        rd_v = 1'b0;
        n = 0;
        while (!pgcb_isol_en && n < 10) begin
            chk("drain_no_extra_resp", rd_resp_v, 1'b0);
            tick();
            n++;
        end
        chk("isol_rise_bound", (n < 10), 1'b1);
        // Reassert during ISO_SET: sequence completes to OFF, then powers up again
        pwr_req = 1'b1;
        chk("en_b_iso0", pwr_enable_b_in, 1'b0);
        tick();
        chk("en_b_iso1", pwr_enable_b_in, 1'b0);
        tick();
        chk("en_b_rise", pwr_enable_b_in, 1'b1);
        n = 0;
        while (!pwr_on && n < 20) begin
            tick();
            n++;
        end
        chk("repower_on", pwr_on, 1'b1);

        // Ack timeout: held off for 70 cycles, error at cycle 64
        pwr_req = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        ack_hold = 1'b1;
        pwr_req = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c == 63) chk("pwr_err@63", pwr_err, 1'b0);
            if (c == 64) chk("pwr_err@64", pwr_err, 1'b1);
            if (c == 70) begin
                chk("pwr_err@70", pwr_err, 1'b1);
                chk("pwr_on_held", pwr_on, 1'b0);
            end
        end
        ack_hold = 1'b0;
        tick();
        tick();
        chk("late_on@72", pwr_on, 1'b0);
        tick();
        chk("late_on@73", pwr_on, 1'b1);
        chk("pwr_err_sticky", pwr_err, 1'b1);

        // Async reset with one read in flight
        rd_v = 1'b1; rd_addr = 5'd5;
        #1;
        chk("midrst_mem_re", mem_re, 1'b1);
        tick();
        rd_v = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_isol", pgcb_isol_en, 1'b1);
        chk("midrst_en_b", pwr_enable_b_in, 1'b1);
        chk("midrst_pwr_on", pwr_on, 1'b0);
        chk("midrst_rd_ready", rd_ready, 1'b0);
        chk("midrst_pwr_err", pwr_err, 1'b0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("midrst_no_resp", rd_resp_v, 1'b0);
        end
        rst_n = 1'b1;
        pwr_req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("postrst_no_resp", rd_resp_v, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hqm_rf_pg_access_ctl.md
# hqm_rf_pg_access_ctl

Client-side access and power-sequencing controller for the power-gated two-port register-file wrappers (e.g. 32x96 list-select arrays). It drives the wrapper's write/read ports and its power interface (`pgcb_isol_en`, `pwr_enable_b_in`, `pwr_enable_b_out`). It accepts client requests only while the array is powered and de-isolated, and returns read data with a fixed latency. Same-address write/read collisions are resolved by forwarding.

## Interface
Parameters:
- AW, 5, address width
- DW, 96, data width
- RD_LAT, 1, wrapper read latency in cycles (rdata valid RD_LAT cycles after re); legal 1..3
- ISO_DLY, 2, cycles between power ack and isolation release (and between isolation assert and power-off)
- PWR_TO, 64, power-ack timeout in cycles before `pwr_err` sets

Ports:
- clk  in  1  single clock; `wclk`/`rclk` of the wrapper are tied to it externally
- rst_n  in  1  reset, asynchronous assert, active-low
- pwr_req  in  1  1 = array is to be powered
- pwr_on  out  1  array usable (state ON)
- pwr_err  out  1  sticky: an ack wait exceeded PWR_TO cycles
- wr_v / wr_ready  in/out  1/1  write request handshake
- wr_addr / wr_data  in  AW/DW  write payload
- rd_v / rd_ready  in/out  1/1  read request handshake
- rd_addr  in  AW  read address
- rd_resp_v / rd_resp_data  out  1/DW  read response; no backpressure
- mem_we / mem_waddr / mem_wdata  out  1/AW/DW  to wrapper write port
- mem_re / mem_raddr  out  1/AW  to wrapper read port
- mem_rdata  in  DW  from wrapper
- pgcb_isol_en / pwr_enable_b_in  out  1/1  to wrapper power interface
- pwr_enable_b_out  in  1  wrapper power-chain ack (0 = powered)

## Operation
- Reset values: pgcb_isol_en=1, pwr_enable_b_in=1, pwr_on=0, pwr_err=0, wr_ready=rd_ready=0, mem_we=mem_re=0, rd_resp_v=0. Addresses and data are 0.
- FSM states: OFF, UP, ISO_REL, ON, DRAIN, ISO_SET, DN.
  - OFF: isol=1, en_b=1. pwr_req=1 -> UP.
  - UP: en_b=0, isol=1. Wait for pwr_enable_b_out==0, then -> ISO_REL.
  - ISO_REL: count ISO_DLY cycles, then isol=0 -> ON.
  - ON: wr_ready=rd_ready=1, pwr_on=1. pwr_req=0 -> DRAIN.
  - DRAIN: ready=0. Wait until outstanding reads == 0 -> ISO_SET.
  - ISO_SET: isol=1. Count ISO_DLY cycles -> DN.
  - DN: en_b=1. Wait for pwr_enable_b_out==1 -> OFF.
- A power-down sequence is never aborted. Reasserting pwr_req in DRAIN/ISO_SET/DN completes the sequence to OFF, then re-enters UP on the next cycle.
- Ack timeout: a saturating counter runs in UP and DN. When it reaches PWR_TO, pwr_err sets, and the FSM keeps waiting. pwr_err clears only on reset.
- Writes:
  - A write is accepted when wr_v && wr_ready.
  - In that same cycle, mem_we=1 and mem_waddr/mem_wdata are driven combinationally from the request.
- Reads:
  - A read is accepted when rd_v && rd_ready; mem_re=1 and mem_raddr are driven combinationally.
  - A shift pipeline of depth RD_LAT carries valid, a fwd flag and fwd data.
  - Response is registered: rd_resp_v/rd_resp_data appear at accept + RD_LAT + 1.
- Collision: a write and a read accepted in the same cycle to the same address set fwd=1. The response then returns that cycle's wr_data, not mem_rdata. Collisions at different addresses, or with a write on a later cycle, return mem_rdata.
- Outstanding counter: +1 per accepted read, -1 per response, width clog2(RD_LAT+2). It never exceeds RD_LAT+1.
- An async reset mid-operation returns all outputs to their reset values immediately. In-flight reads are discarded without a response.

## Timing
- Power-up latency from pwr_req rise with an immediate ack: OFF->UP 1 cycle, UP->ISO_REL 1 cycle after ack, then ISO_DLY cycles. pwr_on rises at cycle 2+ISO_DLY+ack delay.
- Power-down: pwr_on falls the cycle after pwr_req falls. pgcb_isol_en rises once the drain completes. pwr_enable_b_in rises ISO_DLY cycles later.
- Read throughput is 1 per cycle in ON; writes are 1 per cycle concurrently.
- pwr_enable_b_out is used directly (synchronous to clk).

## Test plan
- Reset then pwr_req=1 with pwr_enable_b_out following pwr_enable_b_in after 3 cycles -> pwr_on=1 at cycle 7 (ISO_DLY=2); isol falls the same cycle; pwr_err=0.
- In ON, write addr 5 = 96'hA5A5…, then read addr 5 on a later cycle -> rd_resp_v one cycle after mem_rdata returns, data 96'hA5A5….
- Same-cycle write addr 31 = 96'h1 and read addr 31 (old value 96'h0 in array) -> response 96'h1. Read addr 30 in the same cycle as a write to 31 -> array data.
- Back-to-back reads of addresses 0..31, then drop pwr_req on the cycle of the last accept -> all 32 responses delivered before pgcb_isol_en rises; ready=0 from the next cycle.
- Hold pwr_enable_b_out=1 in UP for 70 cycles -> pwr_err=1 at cycle 64 and stays set. Releasing the ack -> pwr_on=1 ISO_DLY+1 cycles later.
- Assert rst_n=0 with 1 read outstanding in ON -> no response; pgcb_isol_en=1 and pwr_enable_b_in=1 immediately.
